// File: rtl/bf_run_ctrl.sv
// Host run controller for a bf core: loads ASCII programs into opcode RAM and sequences runs.
// Latency: byte accept -> RAM write 1 cycle; load_last -> READY 1 cycle; start -> first core_en 2 cycles.
// Backpressure: load_ready is high only while LOADING; bytes offered in any other state are not taken.
module bf_run_ctrl #(
  parameter int PROGRAM_LENGTH = 256,
  parameter int MAX_DEPTH      = 15,
  parameter int MAX_CYCLES     = 65536,
  parameter int CYC_W          = 32,
  localparam int AW = $clog2(PROGRAM_LENGTH),
  localparam int LW = $clog2(PROGRAM_LENGTH + 1),
  localparam int DW = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       load_data,
  input  logic             load_valid,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             load_begin,
  input  logic             start,
  input  logic             abort,
  output logic             prog_we,
  output logic [AW-1:0]    prog_waddr,
  output logic [2:0]       prog_wdata,
  output logic [LW-1:0]    prog_len,
  output logic             core_rst,
  output logic             core_en,
  input  logic [LW-1:0]    core_pc,
  output logic [CYC_W-1:0] cycles,
  output logic [2:0]       status
);

  typedef enum logic [2:0] {
    S_EMPTY    = 3'd0,
    S_LOADING  = 3'd1,
    S_READY    = 3'd2,
    S_CORE_RST = 3'd3,
    S_RUNNING  = 3'd4,
    S_HALTED   = 3'd5,
    S_TIMEOUT  = 3'd6,
    S_LOAD_ERR = 3'd7
  } state_e;

  localparam logic [2:0] OP_OPEN  = 3'd6;
  localparam logic [2:0] OP_CLOSE = 3'd7;

  state_e           state_q, state_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [LW-1:0]    prog_len_q, prog_len_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [2:0]       wdata_q, wdata_d;
  logic             core_rst_q, core_rst_d;
  logic             load_ready_q, load_ready_d;
  logic [2:0]       status_q, status_d;

  logic             is_cmd;
  logic [2:0]       op;
  logic             byte_acc;
  logic             load_err;
  logic [DW-1:0]    depth_after;
  logic [LW-1:0]    idx_after;
  logic             can_load;
  logic             can_start;
  logic             in_run;

  // Translate one ASCII byte to an opcode; anything else is a comment byte.
  always_comb begin
    is_cmd = 1'b1;
    op     = 3'd0;
    case (load_data)
      8'h2B:   op = 3'd0;  // +
      8'h2D:   op = 3'd1;  // -
      8'h3E:   op = 3'd2;  // >
      8'h3C:   op = 3'd3;  // <
      8'h2E:   op = 3'd4;  // .
      8'h2C:   op = 3'd5;  // ,
      8'h5B:   op = 3'd6;  // [
      8'h5D:   op = 3'd7;  // ]
      default: is_cmd = 1'b0;
    endcase
  end

  // Validate the offered byte against nesting depth and RAM capacity, and precompute loader state after it.
  always_comb begin
    byte_acc    = load_ready_q && load_valid;
    load_err    = is_cmd && (((op == OP_CLOSE) && (depth_q == '0)) ||
                             ((op == OP_OPEN) && (depth_q == DW'(MAX_DEPTH))) ||
                             (idx_q == LW'(PROGRAM_LENGTH)));
    depth_after = depth_q;
    idx_after   = idx_q;
    if (is_cmd) begin
      idx_after = idx_q + LW'(1);
      if (op == OP_OPEN) begin
        depth_after = depth_q + DW'(1);
      end else if (op == OP_CLOSE) begin
        depth_after = depth_q - DW'(1);
      end
    end
  end

  assign in_run    = (state_q == S_CORE_RST) || (state_q == S_RUNNING);
  assign can_load  = !in_run;
  assign can_start = (state_q == S_READY) || (state_q == S_HALTED) || (state_q == S_TIMEOUT);

  // The core steps whenever the run is live and its pc is still inside the program.
  assign core_en = (state_q == S_RUNNING) && (core_pc < prog_len_q);

  // Next-state and datapath: abort beats load_begin beats start, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    depth_d    = depth_q;
    prog_len_d = prog_len_q;
    cycles_d   = cycles_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    if (abort && (state_q == S_LOADING)) begin
      state_d    = S_EMPTY;
      prog_len_d = '0;
    end else if (abort && in_run) begin
      // The enable in flight this cycle still reaches the core, so it is counted.
      state_d = S_READY;
      if (core_en) begin
        cycles_d = cycles_q + CYC_W'(1);
      end
    end else if (load_begin && can_load) begin
      state_d    = S_LOADING;
      idx_d      = '0;
      depth_d    = '0;
      prog_len_d = '0;
      cycles_d   = '0;
    end else if (start && can_start) begin
      state_d  = S_CORE_RST;
      cycles_d = '0;
    end else begin
      case (state_q)
        S_LOADING: begin
          if (byte_acc) begin
            if (load_err) begin
              state_d = S_LOAD_ERR;
            end else begin
              if (is_cmd) begin
                we_d    = 1'b1;
                waddr_d = idx_q[AW-1:0];
                wdata_d = op;
                idx_d   = idx_after;
                depth_d = depth_after;
              end
              if (load_last) begin
                if (depth_after == '0) begin
                  state_d    = S_READY;
                  prog_len_d = idx_after;
                end else begin
                  state_d = S_LOAD_ERR;
                end
              end
            end
          end
        end
        S_CORE_RST: state_d = S_RUNNING;
        S_RUNNING: begin
          if (!core_en) begin
            state_d = S_HALTED;
          end else begin
            cycles_d = cycles_q + CYC_W'(1);
            if (cycles_q == CYC_W'(MAX_CYCLES - 1)) begin
              state_d = S_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered host-visible status derived from the state being entered.
  always_comb begin
    load_ready_d = (state_d == S_LOADING);
    core_rst_d   = (state_d == S_CORE_RST);
    case (state_d)
      S_EMPTY:    status_d = 3'd0;
      S_LOADING:  status_d = 3'd1;
      S_READY:    status_d = 3'd2;
      S_CORE_RST: status_d = 3'd3;
      S_RUNNING:  status_d = 3'd3;
      S_HALTED:   status_d = 3'd4;
      S_TIMEOUT:  status_d = 3'd5;
      default:    status_d = 3'd6;
    endcase
  end

  // State register; the core is held in reset for as long as rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      idx_q        <= '0;
      depth_q      <= '0;
      prog_len_q   <= '0;
      cycles_q     <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      core_rst_q   <= 1'b1;
      load_ready_q <= 1'b0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      depth_q      <= depth_d;
      prog_len_q   <= prog_len_d;
      cycles_q     <= cycles_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_rst_q   <= core_rst_d;
      load_ready_q <= load_ready_d;
      status_q     <= status_d;
    end
  end

  assign load_ready = load_ready_q;
  assign prog_we    = we_q;
  assign prog_waddr = waddr_q;
  assign prog_wdata = wdata_q;
  assign prog_len   = prog_len_q;
  assign cycles     = cycles_q;
  assign core_rst   = core_rst_q;
  assign status     = status_q;

endmodule

// File: tb/tb_bf_run_ctrl.sv
// Bench for bf_run_ctrl: directed and random program loads and runs against a queue-based model.
// Model core advances its pc on every core_en (optionally held to force a timeout).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bf_run_ctrl;
  localparam int PL = 16;
  localparam int MD = 2;
  localparam int MC = 16;
  localparam int CW = 32;
  localparam int AW = $clog2(PL);
  localparam int LW = $clog2(PL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    load_data;
  logic          load_valid, load_last, load_ready, load_begin, start, abort;
  logic          prog_we;
  logic [AW-1:0] prog_waddr;
  logic [2:0]    prog_wdata;
  logic [LW-1:0] prog_len;
  logic          core_rst, core_en;
  logic [LW-1:0] core_pc;
  logic [CW-1:0] cycles;
  logic [2:0]    status;

  int n_cmp = 0;
  int n_bad = 0;
  int got_w[$];
  logic [7:0] prog_q[$];
  int mdl_len = 0;
  int mdl_st  = 0;
  bit pc_hold = 1'b0;

  always #5 clk = ~clk;

  bf_run_ctrl #(.PROGRAM_LENGTH(PL), .MAX_DEPTH(MD), .MAX_CYCLES(MC), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready), .load_begin(load_begin), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata), .prog_len(prog_len),
    .core_rst(core_rst), .core_en(core_en), .core_pc(core_pc), .cycles(cycles), .status(status)
  );

  // Model core: pc restarts on core_rst and advances on each enabled cycle unless held.
  always @(posedge clk) begin
    if (rst || core_rst) core_pc <= '0;
    else if (core_en && !pc_hold) core_pc <= core_pc + LW'(1);
  end

  // Record every program RAM write as addr*8+opcode.
  always @(negedge clk) begin
    if (prog_we === 1'b1) got_w.push_back(int'(prog_waddr) * 8 + int'(prog_wdata));
  end

  function automatic int decode(input logic [7:0] c);
    case (c)
      "+": return 0;
      "-": return 1;
      ">": return 2;
      "<": return 3;
      ".": return 4;
      ",": return 5;
      "[": return 6;
      "]": return 7;
      default: return -1;
    endcase
  endfunction

  // Load a byte stream; expected writes/status/length come from a direct reading of the load rules.
  task automatic run_load(input logic [7:0] b[$], input bit with_last, input string name);
    int depth, idx, n_send, e_status, e_len, op, gap;
    int exp_w[$];
    depth = 0; idx = 0; n_send = b.size(); e_status = 1; e_len = 0;
    for (int i = 0; i < b.size(); i++) begin
      op = decode(b[i]);
      if (op >= 0) begin
        if ((op == 7 && depth == 0) || (op == 6 && depth == MD) || idx == PL) begin
          e_status = 6; n_send = i + 1; break;
        end
        exp_w.push_back(idx * 8 + op);
        idx++;
        if (op == 6) depth++;
        if (op == 7) depth--;
      end
      if (with_last && i == b.size() - 1) begin
        e_status = (depth == 0) ? 2 : 6;
        e_len    = (depth == 0) ? idx : 0;
      end
    end
    load_begin = 1'b1; @(negedge clk); load_begin = 1'b0;
    got_w.delete();
    n_cmp++; if (status !== 3'd1) begin n_bad++; $display("FAIL %s loading_status: got %0d expected 1", name, status); end
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL %s load_ready: got %0b expected 1", name, load_ready); end
    n_cmp++; if (cycles !== '0 || prog_len !== '0) begin n_bad++; $display("FAIL %s clear: got cycles=%0d len=%0d expected 0/0", name, cycles, prog_len); end
    for (int i = 0; i < n_send; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      load_data = b[i]; load_valid = 1'b1; load_last = with_last && (i == b.size() - 1);
      @(negedge clk);
      load_valid = 1'b0; load_last = 1'b0; load_data = 8'($urandom);
    end
    @(negedge clk);
    n_cmp++; if (status !== e_status) begin n_bad++; $display("FAIL %s status: got %0d expected %0d", name, status, e_status); end
    n_cmp++; if (prog_len !== e_len) begin n_bad++; $display("FAIL %s prog_len: got %0d expected %0d", name, prog_len, e_len); end
    n_cmp++; if (got_w.size() != exp_w.size()) begin n_bad++; $display("FAIL %s write_count: got %0d expected %0d", name, got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_cmp++;
      if (got_w[i] != exp_w[i]) begin
        n_bad++; $display("FAIL %s write%0d: got addr %0d op %0d expected addr %0d op %0d", name, i, got_w[i] / 8, got_w[i] % 8, exp_w[i] / 8, exp_w[i] % 8);
      end
    end
    mdl_st  = e_status;
    mdl_len = e_len;
  endtask

  task automatic load_str(input string s, input bit with_last, input string name);
    prog_q.delete();
    for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    run_load(prog_q, with_last, name);
  endtask

  task automatic load_rep(input int n, input bit with_last, input string name);
    prog_q.delete();
    repeat (n) prog_q.push_back("+");
    run_load(prog_q, with_last, name);
  endtask

  // Run the loaded program; expected result: min(len, budget) steps, timeout once the budget is used up.
  task automatic run_prog(input bit hold, input string name);
    int n_en, e_cyc, e_st;
    bit done;
    pc_hold = hold;
    if ((hold && mdl_len > 0) || mdl_len >= MC) begin e_cyc = MC; e_st = 5; end
    else begin e_cyc = mdl_len; e_st = 4; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_cmp++; if (status !== 3'd3 || core_rst !== 1'b1 || core_en !== 1'b0) begin n_bad++; $display("FAIL %s core_rst_phase: got st=%0d rst=%0b en=%0b expected 3/1/0", name, status, core_rst, core_en); end
    n_cmp++; if (cycles !== '0) begin n_bad++; $display("FAIL %s cycles_clear: got %0d expected 0", name, cycles); end
    n_en = 0; done = 1'b0;
    for (int t = 0; t < 4 * MC && !done; t++) begin
      @(negedge clk);
      if (t == 0) begin
        n_cmp++; if (core_en !== (mdl_len > 0) || core_rst !== 1'b0) begin n_bad++; $display("FAIL %s first_en: got en=%0b rst=%0b expected en=%0b rst=0", name, core_en, core_rst, mdl_len > 0); end
      end
      if (core_en === 1'b1) n_en++;
      if (status === 3'd4 || status === 3'd5) done = 1'b1;
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL %s finish: got status %0d expected run to end", name, status); end
    n_cmp++; if (n_en != e_cyc) begin n_bad++; $display("FAIL %s en_count: got %0d expected %0d", name, n_en, e_cyc); end
    n_cmp++; if (cycles !== e_cyc) begin n_bad++; $display("FAIL %s cycles: got %0d expected %0d", name, cycles, e_cyc); end
    n_cmp++; if (status !== e_st) begin n_bad++; $display("FAIL %s end_status: got %0d expected %0d", name, status, e_st); end
    n_cmp++; if (core_en !== 1'b0 || prog_len !== mdl_len) begin n_bad++; $display("FAIL %s end_hold: got en=%0b len=%0d expected 0/%0d", name, core_en, prog_len, mdl_len); end
    mdl_st = e_st; pc_hold = 1'b0;
  endtask

  // Start a run with the pc frozen and abort after k enabled cycles (k=0 aborts during core reset).
  task automatic abort_run(input int k, input string name);
    int n_en;
    pc_hold = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n_en = 0;
    for (int t = 0; t < 4 * MC && n_en < k; t++) begin
      @(negedge clk);
      if (core_en === 1'b1) n_en++;
    end
    n_cmp++; if (n_en != k) begin n_bad++; $display("FAIL %s reach: got %0d enables expected %0d", name, n_en, k); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_cmp++; if (status !== 3'd2) begin n_bad++; $display("FAIL %s status: got %0d expected 2", name, status); end
    n_cmp++; if (cycles !== k) begin n_bad++; $display("FAIL %s cycles: got %0d expected %0d", name, cycles, k); end
    n_cmp++; if (core_en !== 1'b0 || core_rst !== 1'b0) begin n_bad++; $display("FAIL %s quiet: got en=%0b rst=%0b expected 0/0", name, core_en, core_rst); end
    pc_hold = 1'b0; mdl_st = 2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (status !== 3'd0 || core_rst !== 1'b1 || core_en !== 1'b0) begin n_bad++; $display("FAIL reset_ctl: got st=%0d rst=%0b en=%0b expected 0/1/0", status, core_rst, core_en); end
    n_cmp++; if (prog_we !== 1'b0 || prog_len !== '0 || cycles !== '0 || load_ready !== 1'b0) begin n_bad++; $display("FAIL reset_out: got we=%0b len=%0d cyc=%0d rdy=%0b expected all 0", prog_we, prog_len, cycles, load_ready); end
    n_cmp++; if (prog_waddr !== '0 || prog_wdata !== '0) begin n_bad++; $display("FAIL reset_wr: got addr=%0d data=%0d expected 0/0", prog_waddr, prog_wdata); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (core_rst !== 1'b0 || status !== 3'd0) begin n_bad++; $display("FAIL reset_release: got rst=%0b st=%0d expected 0/0", core_rst, status); end
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    n_cmp++; if (status !== 3'd0 || core_en !== 1'b0 || core_rst !== 1'b0) begin n_bad++; $display("FAIL start_in_empty: got st=%0d en=%0b rst=%0b expected 0/0/0", status, core_en, core_rst); end
  endtask

  task automatic test_load_directed();
    load_str("+[-]", 1'b1, "plus_loop");
    load_str("a+\nb", 1'b1, "comments");
    load_str("]", 1'b0, "close_at_zero");
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    n_cmp++; if (status !== 3'd6 || core_en !== 1'b0 || prog_len !== '0) begin n_bad++; $display("FAIL start_in_err: got st=%0d en=%0b len=%0d expected 6/0/0", status, core_en, prog_len); end
    load_str("[[", 1'b1, "unbalanced_last");
    load_str("[[[", 1'b0, "too_deep");
    load_str("q", 1'b1, "zero_len");
    run_prog(1'b0, "zero_run");
    load_rep(PL + 1, 1'b0, "overflow");
    load_rep(PL, 1'b1, "full");
    run_prog(1'b0, "full_run");
    load_rep(MC - 1, 1'b1, "fifteen");
    run_prog(1'b0, "fifteen_run");
  endtask

  task automatic test_run();
    load_str("+>+<", 1'b1, "prog4");
    run_prog(1'b0, "run4_first");
    run_prog(1'b0, "run4_again");
  endtask

  task automatic test_timeout_abort();
    load_str("++++", 1'b1, "prog4_to");
    run_prog(1'b1, "timeout");
    abort_run(5, "abort5");
    abort_run(0, "abort_core_rst");
    abort_run($urandom_range(1, MC), "abort_rnd");
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    n_cmp++; if (status !== 3'd2 || prog_len !== 4) begin n_bad++; $display("FAIL abort_in_ready: got st=%0d len=%0d expected 2/4", status, prog_len); end
    run_prog(1'b0, "rerun_after_abort");
  endtask

  task automatic test_abort_load();
    load_begin = 1'b1; @(negedge clk); load_begin = 1'b0;
    load_data = "+"; load_valid = 1'b1; @(negedge clk); load_valid = 1'b0;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_cmp++; if (status !== 3'd0 || prog_len !== '0 || load_ready !== 1'b0) begin n_bad++; $display("FAIL abort_load: got st=%0d len=%0d rdy=%0b expected 0/0/0", status, prog_len, load_ready); end
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
    n_cmp++; if (status !== 3'd0 || core_en !== 1'b0) begin n_bad++; $display("FAIL start_after_abort_load: got st=%0d en=%0b expected 0/0", status, core_en); end
  endtask

  task automatic gen_prog(input bit good);
    string alpha;
    int depth, n;
    logic [7:0] c;
    alpha = "+-<>.,[]ab\n ";
    prog_q.delete(); depth = 0;
    n = good ? $urandom_range(0, 14) : $urandom_range(0, 20);
    for (int i = 0; i < n; i++) begin
      c = alpha[$urandom_range(0, alpha.len() - 1)];
      if (good && c == "]" && depth == 0) c = "+";
      if (good && c == "[" && depth == MD) c = "-";
      if (c == "[") depth++;
      if (c == "]" && depth > 0) depth--;
      prog_q.push_back(c);
    end
    if (good) begin
      repeat (depth) prog_q.push_back("]");
      prog_q.push_back("z");
    end
  endtask

  task automatic test_random();
    bit good, last;
    for (int it = 0; it < 30; it++) begin
      good = ($urandom_range(0, 3) != 0);
      gen_prog(good);
      last = ($urandom_range(0, 7) != 0) && (prog_q.size() > 0);
      run_load(prog_q, last, $sformatf("rnd%0d", it));
      if (mdl_st == 2) run_prog(1'b0, $sformatf("rndrun%0d", it));
    end
  endtask

  task automatic test_rst_midrun();
    load_str("++++", 1'b1, "prog4_rst");
    pc_hold = 1'b1;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (core_en !== 1'b1 || status !== 3'd3) begin n_bad++; $display("FAIL pre_rst_running: got en=%0b st=%0d expected 1/3", core_en, status); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (status !== 3'd0 || core_en !== 1'b0 || prog_len !== '0) begin n_bad++; $display("FAIL async_rst: got st=%0d en=%0b len=%0d expected 0/0/0", status, core_en, prog_len); end
    n_cmp++; if (core_rst !== 1'b1 || cycles !== '0) begin n_bad++; $display("FAIL async_rst_core: got rst=%0b cyc=%0d expected 1/0", core_rst, cycles); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (status !== 3'd0 || core_en !== 1'b0 || core_rst !== 1'b0) begin n_bad++; $display("FAIL start_after_rst: got st=%0d en=%0b rst=%0b expected 0/0/0", status, core_en, core_rst); end
    pc_hold = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; load_data = '0; load_valid = 1'b0; load_last = 1'b0;
    load_begin = 1'b0; start = 1'b0; abort = 1'b0;
    test_reset();
    test_load_directed();
    test_run();
    test_timeout_abort();
    test_abort_load();
    test_random();
    test_rst_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bf_run_ctrl.md
Name: bf_run_ctrl

Overview:
- Host-facing run controller for one bf_machine-style core with writable program memory.
- Accepts a program as an ASCII byte stream, decodes it to 3-bit opcodes, writes them to program RAM, and checks bracket balance while loading.
- Sequences execution: core reset pulse, step enable, halt detection and cycle-budget timeout. Reports status to the host.

Parameters:
- PROGRAM_LENGTH, 256, program RAM depth in opcodes.
- MAX_DEPTH, 15, maximum legal bracket nesting depth.
- MAX_CYCLES, 65536, cycle budget per run; must be >= 1.
- CYC_W, 32, width of the cycle counter output.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- load_data  in  8  ASCII program byte
- load_valid  in  1  byte valid
- load_last  in  1  marks the final byte of the program; qualified by load_valid
- load_ready  out  1  controller accepts a byte
- load_begin  in  1  one-cycle pulse; starts a new load
- start  in  1  one-cycle pulse; run the loaded program
- abort  in  1  one-cycle pulse; cancel the current load or run
- prog_we  out  1  program RAM write enable
- prog_waddr  out  $clog2(PROGRAM_LENGTH)  write address
- prog_wdata  out  3  opcode
- prog_len  out  $clog2(PROGRAM_LENGTH+1)  opcode count of the loaded program
- core_rst  out  1  synchronous reset to the core
- core_en  out  1  core advances one instruction this cycle
- core_pc  in  $clog2(PROGRAM_LENGTH+1)  core program pointer
- cycles  out  CYC_W  number of core_en cycles in the current/last run
- status  out  3  0 EMPTY, 1 LOADING, 2 READY, 3 RUNNING, 4 HALTED, 5 TIMEOUT, 6 LOAD_ERR

Behaviour:
- Reset (async):
  - State EMPTY.
  - All outputs 0, including prog_len, cycles, prog_we and core_en.
  - core_rst=1 while rst is asserted; core_rst=0 from the first cycle after rst deasserts.
- States: EMPTY, LOADING, READY, CORE_RST, RUNNING, HALTED, TIMEOUT, LOAD_ERR. status shows CORE_RST as 3.
- load_begin:
  - Accepted in every state except CORE_RST and RUNNING.
  - Enters LOADING and clears write index, depth counter, prog_len and cycles.
- LOADING:
  - load_ready=1. A byte is accepted when load_valid && load_ready.
  - Opcode decode: + 0, - 1, > 2, < 3, . 4, , 5, [ 6, ] 7. Every other byte is consumed and discarded.
  - Each command byte is written to RAM registered: prog_we, prog_waddr and prog_wdata are valid on the cycle after acceptance. The write index then increments.
  - Depth rules: [ increments depth; ] decrements it.
  - Any of the following moves the controller to LOAD_ERR on the cycle after acceptance, with no RAM write for that byte:
    - ] at depth 0
    - [ at depth MAX_DEPTH
    - a command byte when the index already equals PROGRAM_LENGTH
  - load_last: after the byte is processed, the next state is READY if depth==0, else LOAD_ERR. prog_len = final index, updated on the same cycle as the last write.
  - A zero-length program is legal.
- LOAD_ERR:
  - load_ready=0; prog_len=0.
  - start is ignored. Only load_begin or reset exits.
- start:
  - Accepted in READY, HALTED and TIMEOUT. Ignored in every other state.
  - Clears cycles and enters CORE_RST: core_rst=1 and core_en=0 for exactly one cycle, then RUNNING.
- RUNNING:
  - core_en = (core_pc < prog_len), combinational.
  - Each cycle with core_en=1, cycles increments.
  - core_en=0 goes to HALTED on the next edge.
  - If core_en=1 and cycles==MAX_CYCLES-1, the controller goes to TIMEOUT on the next edge with cycles=MAX_CYCLES. Halt is checked first.
- HALTED and TIMEOUT: core_en=0. cycles and prog_len are held; the program is retained and can be re-run with start.
- abort:
  - LOADING goes to EMPTY, with prog_len=0.
  - CORE_RST or RUNNING goes to READY, with core_en=0 on the next cycle and cycles held.
  - Ignored in all other states.
- Priority in the same cycle: abort > load_begin > start.
- Async rst mid-load or mid-run: immediately EMPTY. The RAM contents are not cleared, but prog_len=0 invalidates them.
- Latencies:
  - start to first core_en=1: 2 cycles.
  - load_last acceptance to status READY: 1 cycle.

Test Plan:
- Load "+[-]" with load_last on ] -> writes (0,6),(1,1),(2,6)?? no: writes addr0=0, addr1=6, addr2=1, addr3=7; prog_len=4; status=2.
- Load "a+\nb" with load_last on b -> one write, addr0=0; prog_len=1; status=2.
- Load "]" -> no write, status=6. Load "[[" then last -> status=6. With MAX_DEPTH=2, "[[[" -> status=6 after the third [.
- Program len 4 with a model core whose pc increments each core_en; start -> core_rst pulse 1 cycle, 4 core_en cycles, status=4, cycles=4. Start again -> same result.
- MAX_CYCLES=16, core_pc held at 0 -> status=5 after 16 enable cycles, cycles=16. An abort at cycle 5 of a second run -> status=2, cycles=5, core_en=0.
- Assert rst while RUNNING -> status=0, core_en=0 with no clock edge, prog_len=0; start afterwards is ignored.
